core_irq_ctrl: RTL and testbench
================================

# core_irq_ctrl

Core-side interrupt collector sitting directly downstream of the timer block's `irq_timer_o`, and of the software, external and fast interrupt lines. It registers and latches pending interrupts and masks them with the core's enable CSRs. It arbitrates by fixed RISC-V priority and presents one request/ID to the core through a valid/ack handshake with a post-ack holdoff. It also drives a WFI wake signal that ignores the global enable.

## Interface
Parameters:
- `NumFast`, default 15: number of edge-triggered fast interrupts; legal range 0..15.
- `HoldOff`, default 2: idle cycles forced after each ack; legal range 0..15.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `irq_timer_i`  in  1  level; machine timer interrupt (MTI).
- `irq_software_i`  in  1  level; machine software interrupt (MSI).
- `irq_external_i`  in  1  level; machine external interrupt (MEI).
- `irq_fast_i`  in  NumFast  rising-edge fast interrupts.
- `mie_i`  in  3+NumFast  per-source enable, ordered `{fast[NumFast-1:0], MEI, MTI, MSI}`.
- `mstatus_mie_i`  in  1  global interrupt enable.
- `irq_req_o`  out  1  request to core.
- `irq_id_o`  out  5  cause ID; stable while `irq_req_o`=1.
- `irq_ack_i`  in  1  core accepts the request; only meaningful when `irq_req_o`=1.
- `irq_pending_o`  out  3+NumFast  mip mirror, same ordering as `mie_i`.
- `wfi_wake_o`  out  1  `|(irq_pending_o & mie_i)`, independent of `mstatus_mie_i`.

## Operation
- Pending register, updated every cycle:
  - Bits for MSI, MTI and MEI copy their inputs, so they are level-sensitive.
  - Fast bit i sets on a rising edge of `irq_fast_i[i]`, using a registered previous-value flop.
  - Fast bit i clears only when an ack completes with ID 16+i.
- Eligible set = `pending & mie_i`, gated by `mstatus_mie_i`.
- Priority, highest first: MEI (ID 11), MSI (ID 3), MTI (ID 7), then fast[0] .. fast[NumFast-1] (ID 16+i).
- FSM states:
  - IDLE → REQ when the eligible set is non-zero. The winner ID is latched on this transition.
  - REQ → HOLD when `irq_ack_i`=1. If the latched ID is a fast source, its pending bit clears in the same cycle.
  - REQ → IDLE (withdraw) when the latched source is a level source and no longer eligible: its pending bit, its `mie_i` bit, or `mstatus_mie_i` has dropped. Fast requests are withdrawn only by a `mie_i` or `mstatus_mie_i` drop.
  - HOLD → IDLE after `HoldOff` cycles, counted by a 4-bit down-counter. If `HoldOff`=0, the ack cycle goes straight to IDLE.
- No re-arbitration in REQ: a higher-priority arrival waits for ack or withdraw.
- `irq_req_o` = (state==REQ). `irq_id_o` = latched ID while in REQ, and 0 otherwise.
- Ack outside REQ is ignored.

## Timing
- Reset values: every output and all state are 0. State is IDLE, the pending register and edge flops are 0, and the holdoff counter is 0.
- Latency, input to `irq_pending_o`: 1 cycle, or 3 cycles with the synchronizer compiled in.
- Latency, pending eligible to `irq_req_o`: 1 cycle. Total MTI input to `irq_req_o` is 2 cycles.
- `irq_req_o` falls the cycle after the ack cycle.
- Next earliest request: 1+HoldOff cycles after the ack cycle.
- Fast edge in the same cycle as the ack-clear of the same bit: the set wins and the bit stays 1.
- A fast input held high produces exactly one pending event.
- Reset asserted mid-REQ: the next cycle shows `irq_req_o`=0, `irq_id_o`=0, and the pending register cleared. Edge flops reset to 0, so a fast input that is high when reset releases registers as an edge.
- With `mstatus_mie_i`=0, `wfi_wake_o` still follows `pending & mie_i` with no added latency.

## Configuration
- Macro `CORE_IRQ_CTRL_SYNC_EN`.
  - Defined: every interrupt input passes through a 2-flop synchronizer before pending and edge logic; asynchronous sources are allowed.
  - Undefined: inputs are sampled directly; all sources must be synchronous to `clk_i`.
  - Defined adds exactly 2 cycles to every input-to-pending path. All other timing is unchanged.

## Test plan
- MTI basic: mie=MTI, mstatus=1, raise `irq_timer_i` → `irq_req_o`=1 with ID 7 two cycles later; ack → req low next cycle, and no req for 2 cycles (HoldOff=2) even though MTI is still high, then req with ID 7 again.
- Priority: assert MTI, MSI and MEI in the same cycle, all enabled → ID 11; ack, drop MEI → after holdoff, ID 3; ack, drop MSI → ID 7.
- Withdraw: MTI request pending, deassert `irq_timer_i` before ack → req falls 2 cycles later (pending update plus FSM), ID 0, no HOLD entered.
- Fast latch: pulse `irq_fast_i[2]` for 1 cycle with mie enabled → pending bit sticks, ID 18; on ack the bit clears. A new edge coincident with the ack keeps the bit set, and ID 18 reappears after holdoff.
- WFI: `mstatus_mie_i`=0, MEI pending and enabled → `wfi_wake_o`=1, `irq_req_o` stays 0; set `mstatus_mie_i`=1 → req with ID 11 the next cycle.
- Reset mid-request: assert `rst_ni`=0 while in REQ → on the next edge all outputs are 0. With `CORE_IRQ_CTRL_SYNC_EN` defined, MTI input to req is 4 cycles.

Source files
------------

// File: rtl/core_irq_ctrl.sv
// Core interrupt collector: latches MSI/MTI/MEI/fast sources, masks with mie, arbitrates by fixed
// priority and presents one request/ID per valid/ack handshake. Define CORE_IRQ_CTRL_SYNC_EN for 2-flop input sync.
module core_irq_ctrl #(
  parameter int NumFast = 15,
  parameter int HoldOff = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               irq_timer_i,
  input  logic               irq_software_i,
  input  logic               irq_external_i,
  input  logic [NumFast-1:0] irq_fast_i,
  input  logic [NumFast+2:0] mie_i,
  input  logic               mstatus_mie_i,
  output logic               irq_req_o,
  output logic [4:0]         irq_id_o,
  input  logic               irq_ack_i,
  output logic [NumFast+2:0] irq_pending_o,
  output logic               wfi_wake_o
);

  localparam int W  = NumFast + 3;
  localparam int SW = $clog2(W);
  localparam int FW = (NumFast > 0) ? NumFast : 1;
  localparam logic [3:0] HoldLast = (HoldOff == 0) ? 4'd0 : 4'(HoldOff - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [4:0]    id_q, id_d;
  logic [SW-1:0] src_q, src_d;
  logic [W-1:0]  pend_q, pend_d;
  logic [FW-1:0] fprev_q, fprev_d;

  logic [W-1:0]  raw_in, in_s, elig;
  logic          ack_fire, win_valid;
  logic [SW-1:0] win_src;
  logic [4:0]    win_id;

  // Bit order everywhere: {fast[NumFast-1:0], MEI, MTI, MSI}.
  always_comb begin
    raw_in    = '0;
    raw_in[0] = irq_software_i;
    raw_in[1] = irq_timer_i;
    raw_in[2] = irq_external_i;
    for (int i = 0; i < NumFast; i++) raw_in[3+i] = irq_fast_i[i];
  end

`ifdef CORE_IRQ_CTRL_SYNC_EN
  logic [W-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = raw_in;
`endif

  // Handshake: irq_req_o/irq_id_o form a valid that holds until irq_ack_i is seen in the same
  // cycle (transfer) or the source stops being eligible (withdraw); ack without req is ignored.
  assign ack_fire = (state_q == StReq) && irq_ack_i;

  always_comb begin
    pend_d      = '0;
    fprev_d     = '0;
    pend_d[2:0] = in_s[2:0];
    for (int i = 0; i < NumFast; i++) begin
      fprev_d[i]  = in_s[3+i];
      // A new edge beats the ack-clear of the same bit.
      pend_d[3+i] = (in_s[3+i] & ~fprev_q[i]) |
                    (pend_q[3+i] & ~(ack_fire && (src_q == SW'(3 + i))));
    end
  end

  assign elig = pend_q & mie_i & {W{mstatus_mie_i}};

  // Lowest priority assigned first so higher-priority sources override.
  always_comb begin
    win_valid = |elig;
    win_src   = '0;
    win_id    = '0;
    for (int i = NumFast - 1; i >= 0; i--) begin
      if (elig[3+i]) begin
        win_src = SW'(3 + i);
        win_id  = 5'(16 + i);
      end
    end
    if (elig[1]) begin
      win_src = SW'(1);
      win_id  = 5'd7;
    end
    if (elig[0]) begin
      win_src = SW'(0);
      win_id  = 5'd3;
    end
    if (elig[2]) begin
      win_src = SW'(2);
      win_id  = 5'd11;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    src_d   = src_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = StReq;
          id_d    = win_id;
          src_d   = win_src;
        end
      end
      StReq: begin
        if (irq_ack_i) begin
          if (HoldOff == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StHold;
            cnt_d   = HoldLast;
          end
        end else if (!elig[src_q]) begin
          // Fast pending bits only clear on ack, so for them this reduces to an enable drop.
          state_d = StIdle;
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) state_d = StIdle;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      id_q    <= '0;
      src_q   <= '0;
      pend_q  <= '0;
      fprev_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      src_q   <= src_d;
      pend_q  <= pend_d;
      fprev_q <= fprev_d;
    end
  end

  assign irq_req_o     = (state_q == StReq);
  assign irq_id_o      = irq_req_o ? id_q : 5'd0;
  assign irq_pending_o = pend_q;
  assign wfi_wake_o    = |(pend_q & mie_i);

endmodule

// File: tb/tb_core_irq_ctrl.sv
// Bench for core_irq_ctrl: vector table, directed corner sequences and random traffic,
// all cross-checked every cycle against a behavioural model of the collector.
module tb_core_irq_ctrl;

  localparam int NumFast = 15;
  localparam int HoldOff = 2;
  localparam int W       = NumFast + 3;
`ifdef CORE_IRQ_CTRL_SYNC_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               timer = 1'b0, sw = 1'b0, ext = 1'b0, mstatus = 1'b0, ack = 1'b0;
  logic [NumFast-1:0] fast = '0;
  logic [W-1:0]       mie = '0;
  logic               req, wake;
  logic [4:0]         id;
  logic [W-1:0]       pend;

  always #5 clk = ~clk;

  core_irq_ctrl #(.NumFast(NumFast), .HoldOff(HoldOff)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .irq_timer_i   (timer),
    .irq_software_i(sw),
    .irq_external_i(ext),
    .irq_fast_i    (fast),
    .mie_i         (mie),
    .mstatus_mie_i (mstatus),
    .irq_req_o     (req),
    .irq_id_o      (id),
    .irq_ack_i     (ack),
    .irq_pending_o (pend),
    .wfi_wake_o    (wake)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Sources are numbered by mip bit; m_src = -1 means no request presented.
  logic [W-1:0]       m_pend = '0, m_pipe0 = '0, m_pipe1 = '0;
  logic [NumFast-1:0] m_prev = '0;
  int                 m_src = -1;
  int                 m_quiet = 0;
  int                 prio[W];
  logic [W-1:0]       exp_q[$];

  function automatic int src_to_id(input int s);
    if (s == 2) return 11;
    if (s == 0) return 3;
    if (s == 1) return 7;
    return 16 + (s - 3);
  endfunction

  task automatic model_step();
    logic [W-1:0] raw, eff, elg;
    bit           ack_done, found;
    int           done_src;
    raw = {fast, ext, timer, sw};
    if (!rst_n) begin
      m_pend = '0; m_prev = '0; m_pipe0 = '0; m_pipe1 = '0;
      m_src = -1; m_quiet = 0;
      exp_q.push_back(m_pend);
      return;
    end
`ifdef CORE_IRQ_CTRL_SYNC_EN
    eff = m_pipe1;
`else
    eff = raw;
`endif
    m_pipe1 = m_pipe0;
    m_pipe0 = raw;
    elg = mstatus ? (m_pend & mie) : '0;
    ack_done = 1'b0;
    done_src = -1;
    if (m_src >= 0) begin
      if (ack) begin
        ack_done = 1'b1; done_src = m_src; m_src = -1; m_quiet = HoldOff;
      end else if (!mie[m_src] || !mstatus || (m_src < 3 && !m_pend[m_src])) begin
        m_src = -1;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else begin
      found = 1'b0;
      for (int k = 0; k < W; k++) begin
        if (!found && elg[prio[k]]) begin
          m_src = prio[k]; found = 1'b1;
        end
      end
    end
    m_pend[2:0] = eff[2:0];
    for (int i = 0; i < NumFast; i++) begin
      if (eff[3+i] && !m_prev[i]) m_pend[3+i] = 1'b1;
      else if (ack_done && done_src == 3 + i) m_pend[3+i] = 1'b0;
    end
    m_prev = eff[W-1:3];
    exp_q.push_back(m_pend);
  endtask

  task automatic model_check();
    logic [W-1:0] e_pend;
    e_pend = '0;
    if (exp_q.size() > 0) e_pend = exp_q.pop_front();
    chk("mdl_req", req, (m_src >= 0) ? 1 : 0);
    chk("mdl_id", id, (m_src >= 0) ? src_to_id(m_src) : 0);
    chk("mdl_pend", pend, e_pend);
    chk("mdl_wake", wake, |(e_pend & mie));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    timer = 0; sw = 0; ext = 0; fast = '0; ack = 0; mie = '0; mstatus = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input string name, input int budget);
    int n;
    n = 0;
    while (req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, req, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic               t, s, e;
    logic [NumFast-1:0] f;
    logic [W-1:0]       en;
    logic               ms;
    logic               x_req;
    logic [4:0]         x_id;
    logic [W-1:0]       x_pend;
    logic               x_wake;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    prio[0] = 2; prio[1] = 0; prio[2] = 1;
    for (int i = 0; i < NumFast; i++) prio[3+i] = 3 + i;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 15'h0000, 18'h00002, 1'b1, 1'b1, 5'd7,  18'h00002, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 15'h0000, 18'h00007, 1'b1, 1'b1, 5'd11, 18'h00007, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 15'h0000, 18'h00007, 1'b1, 1'b1, 5'd3,  18'h00003, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 15'h0000, 18'h00003, 1'b1, 1'b1, 5'd3,  18'h00007, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 15'h0000, 18'h00007, 1'b0, 1'b0, 5'd0,  18'h00004, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 15'h0000, 18'h00003, 1'b1, 1'b0, 5'd0,  18'h00004, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 15'h0004, 18'h00020, 1'b1, 1'b1, 5'd18, 18'h00020, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 15'h0084, 18'h3FFFF, 1'b1, 1'b1, 5'd18, 18'h00420, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 15'h0080, 18'h3FFFF, 1'b1, 1'b1, 5'd7,  18'h00402, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 15'h4000, 18'h3FFFF, 1'b1, 1'b1, 5'd30, 18'h20000, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 15'h0000, 18'h3FFFF, 1'b1, 1'b0, 5'd0,  18'h00000, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 15'h0080, 18'h00020, 1'b1, 1'b0, 5'd0,  18'h00400, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 15'h0001, 18'h00008, 1'b1, 1'b1, 5'd16, 18'h0000C, 1'b1};

    // Reset state
    do_reset();
    chk("rst_req", req, 0);
    chk("rst_id", id, 0);
    chk("rst_pend", pend, 0);
    chk("rst_wake", wake, 0);

    // Table: apply a static input pattern from reset and let it settle
    for (int v = 0; v < 13; v++) begin
      do_reset();
      timer = tbl[v].t; sw = tbl[v].s; ext = tbl[v].e; fast = tbl[v].f;
      mie = tbl[v].en; mstatus = tbl[v].ms;
      repeat (6) tick();
      chk($sformatf("tbl%0d_req", v), req, tbl[v].x_req);
      chk($sformatf("tbl%0d_id", v), id, tbl[v].x_id);
      chk($sformatf("tbl%0d_pend", v), pend, tbl[v].x_pend);
      chk($sformatf("tbl%0d_wake", v), wake, tbl[v].x_wake);
    end

    // MTI latency, ack, holdoff, re-request
    do_reset();
    mie = 18'h00002; mstatus = 1; timer = 1;
    repeat (Lat) tick();
    chk("mti_early", req, 0);
    tick();
    chk("mti_req", req, 1);
    chk("mti_id", id, 7);
    ack = 1; tick(); ack = 0;
    chk("mti_ack_drop", req, 0);
    for (int k = 0; k < HoldOff; k++) begin
      tick();
      chk("mti_holdoff", req, 0);
    end
    tick();
    chk("mti_rereq", req, 1);
    chk("mti_reid", id, 7);

    // Withdraw: level source drops before ack, no holdoff afterwards
    timer = 0;
    repeat (Lat) tick();
    chk("wd_still", req, 1);
    tick();
    chk("wd_req", req, 0);
    chk("wd_id", id, 0);
    timer = 1;
    repeat (Lat) tick();
    chk("wd_gap", req, 0);
    tick();
    chk("wd_no_hold", req, 1);

    // Priority walk
    do_reset();
    mie = 18'h00007; mstatus = 1; timer = 1; sw = 1; ext = 1;
    wait_req("pri_first", 20);
    chk("pri_mei", id, 11);
    ack = 1; tick(); ack = 0; ext = 0;
    wait_req("pri_second", 20);
    chk("pri_msi", id, 3);
    ack = 1; tick(); ack = 0; sw = 0;
    wait_req("pri_third", 20);
    chk("pri_mti", id, 7);

    // Fast latch, ack-clear, coincident edge, held-high single event
    do_reset();
    mie = 18'h00020; mstatus = 1;
    fast = 15'h0004; tick(); fast = '0;
    repeat (Lat) tick();
    chk("fast_req", req, 1);
    chk("fast_id", id, 18);
    chk("fast_sticky", pend[5], 1);
    ack = 1; tick(); ack = 0;
    chk("fast_clear", pend[5], 0);
    fast = 15'h0004; tick(); fast = '0;
    wait_req("fast_rearm", 20);
    chk("fast_rearm_id", id, 18);
    fast = 15'h0004;
    repeat (Lat - 1) tick();
    ack = 1; tick(); ack = 0;
    chk("fast_set_wins", pend[5], 1);
    chk("fast_set_req", req, 0);
    repeat (HoldOff) tick();
    tick();
    chk("fast_reappear", req, 1);
    chk("fast_reappear_id", id, 18);
    ack = 1; tick(); ack = 0;
    chk("fast_held_once", pend[5], 0);
    repeat (6) tick();
    chk("fast_held_pend", pend[5], 0);
    chk("fast_held_noreq", req, 0);
    fast = '0;

    // WFI wake ignores global enable
    do_reset();
    ext = 1; mie = 18'h00004; mstatus = 0;
    repeat (Lat) tick();
    chk("wfi_wake", wake, 1);
    repeat (3) tick();
    chk("wfi_no_req", req, 0);
    mstatus = 1;
    tick();
    chk("wfi_req", req, 1);
    chk("wfi_id", id, 11);

    // Reset mid-request; fast input high at release registers as an edge
    rst_n = 0; ext = 0; fast = 15'h0004; mie = 18'h00020;
    tick();
    chk("rmid_req", req, 0);
    chk("rmid_id", id, 0);
    chk("rmid_pend", pend, 0);
    chk("rmid_wake", wake, 0);
    rst_n = 1;
    wait_req("rmid_edge", 20);
    chk("rmid_edge_id", id, 18);
    fast = '0;

    // Random traffic against the model
    do_reset();
    mie = 18'h3FFFF; mstatus = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) timer = ~timer;
      if ($urandom_range(0, 7) == 0) sw = ~sw;
      if ($urandom_range(0, 9) == 0) ext = ~ext;
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, NumFast - 1);
        fast[k] = ~fast[k];
      end
      if ($urandom_range(0, 49) == 0) mie = W'($urandom);
      if ($urandom_range(0, 29) == 0) mstatus = ($urandom_range(0, 3) != 0);
      ack = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    ack = 0; rst_n = 1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
